// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty fader: FSM states, register map and CTRL bit positions.
package pwm_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, STEP} fade_state_t;

  localparam logic [1:0] ADDR_TARGET = 2'd0;
  localparam logic [1:0] ADDR_STEP   = 2'd1;
  localparam logic [1:0] ADDR_RATE   = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int EN_BIT  = 0;
  localparam int IMM_BIT = 1;

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running PWM period counter; PERIOD_TICK is high on the last cycle of each period.
module pwm_period_timer #(
  parameter int PERIOD_LEN = 256
) (
  input  logic CLK,
  input  logic RST,
  output logic PERIOD_TICK
);

  localparam logic [7:0] LAST = 8'(PERIOD_LEN - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_nx;

  always_comb begin
    cnt_nx = (cnt_q == LAST) ? 8'd0 : cnt_q + 8'd1;
  end

  // Tick is registered from the next count so it lines up with cnt_q == LAST.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q       <= 8'd0;
      PERIOD_TICK <= 1'b0;
    end else begin
      cnt_q       <= cnt_nx;
      PERIOD_TICK <= (cnt_nx == LAST);
    end
  end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Ramps the PWM duty toward a written target, one step per (RATE+1) periods,
// updating DUTY only on the first cycle of a period.
module pwm_fade_ctrl
  import pwm_pkg::*;
#(
  parameter int PERIOD_LEN = 256
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       WR_EN,
  input  logic [1:0] WR_ADDR,
  input  logic [7:0] WR_DATA,
  output logic [7:0] DUTY,
  output logic       PERIOD_TICK,
  output logic       BUSY,
  output logic       DONE
);

  fade_state_t state_q;
  logic [7:0]  tgt_q, step_q, rate_q, wait_q;
  logic        en_q, imm_q;

  logic        wr_tgt, wr_step, wr_rate, wr_ctrl;
  logic [7:0]  tgt_nx, rate_nx, duty_step;
  logic        en_nx;

  // 9-bit intermediates keep both directions free of wrap-around.
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt,
                                             input logic [7:0] stp, input logic imm);
    logic [8:0] sum;
    logic [8:0] dif;
    logic [7:0] res;
    sum = {1'b0, cur} + {1'b0, stp};
    dif = (stp > cur) ? 9'd0 : ({1'b0, cur} - {1'b0, stp});
    if (imm || (cur == tgt))
      res = tgt;
    else if (cur < tgt)
      res = (sum > {1'b0, tgt}) ? tgt : sum[7:0];
    else
      res = (dif < {1'b0, tgt}) ? tgt : dif[7:0];
    return res;
  endfunction

  pwm_period_timer #(.PERIOD_LEN(PERIOD_LEN)) u_timer (
    .CLK         (CLK),
    .RST         (RST),
    .PERIOD_TICK (PERIOD_TICK)
  );

  always_comb begin
    wr_tgt    = WR_EN && (WR_ADDR == ADDR_TARGET);
    wr_step   = WR_EN && (WR_ADDR == ADDR_STEP);
    wr_rate   = WR_EN && (WR_ADDR == ADDR_RATE);
    wr_ctrl   = WR_EN && (WR_ADDR == ADDR_CTRL);
    tgt_nx    = wr_tgt  ? WR_DATA : tgt_q;
    rate_nx   = wr_rate ? WR_DATA : rate_q;
    en_nx     = wr_ctrl ? WR_DATA[EN_BIT] : en_q;
    duty_step = step_toward(DUTY, tgt_q, step_q, imm_q);
  end

  // A step uses the old target; DONE is judged against the target as it will be after this edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      tgt_q   <= 8'h00;
      step_q  <= 8'h01;
      rate_q  <= 8'h00;
      wait_q  <= 8'h00;
      en_q    <= 1'b0;
      imm_q   <= 1'b0;
      DUTY    <= 8'h00;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (wr_tgt)  tgt_q  <= WR_DATA;
      if (wr_step) step_q <= (WR_DATA == 8'h00) ? 8'h01 : WR_DATA;
      if (wr_rate) rate_q <= WR_DATA;
      if (wr_ctrl) begin
        en_q  <= WR_DATA[EN_BIT];
        imm_q <= WR_DATA[IMM_BIT];
      end
      case (state_q)
        IDLE: begin
          if (en_nx && (DUTY != tgt_nx)) begin
            state_q <= WAIT;
            wait_q  <= rate_nx;
            BUSY    <= 1'b1;
          end
        end
        WAIT: begin
          if (!en_nx) begin
            state_q <= IDLE;
            BUSY    <= 1'b0;
          end else if (PERIOD_TICK) begin
            if (wait_q == 8'd0) begin
              DUTY    <= duty_step;
              DONE    <= (duty_step == tgt_nx);
              state_q <= STEP;
            end else begin
              wait_q <= wait_q - 8'd1;
            end
          end
        end
        STEP: begin
          if ((DUTY == tgt_q) || !en_nx) begin
            state_q <= IDLE;
            BUSY    <= 1'b0;
          end else begin
            state_q <= WAIT;
            wait_q  <= rate_nx;
          end
        end
        default: begin
          state_q <= IDLE;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl: vector table of writes/tick waits with expected outputs,
// plus hand sequences for idle behaviour, a target write on the step edge, and reset mid-ramp.
module tb_pwm_fade_ctrl;
  import pwm_pkg::*;

  logic       CLK;
  logic       RST;
  logic       WR_EN;
  logic [1:0] WR_ADDR;
  logic [7:0] WR_DATA;
  logic [7:0] DUTY;
  logic       PERIOD_TICK;
  logic       BUSY;
  logic       DONE;

  pwm_fade_ctrl #(.PERIOD_LEN(256)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .WR_EN       (WR_EN),
    .WR_ADDR     (WR_ADDR),
    .WR_DATA     (WR_DATA),
    .DUTY        (DUTY),
    .PERIOD_TICK (PERIOD_TICK),
    .BUSY        (BUSY),
    .DONE        (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       wr;
    logic [1:0] addr;
    logic [7:0] data;
    int         ticks;
    int         extra;
    logic [7:0] duty;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vt[$];
  int   total = 0;
  int   bad = 0;
  int   done_seen = 0;
  int   exp_done = 0;

  always @(negedge CLK) if (DONE === 1'b1) done_seen++;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h exp=%0h", nm, id, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    WR_EN   = 1'b1;
    WR_ADDR = a;
    WR_DATA = d;
    cyc();
    WR_EN   = 1'b0;
    WR_ADDR = 2'd0;
    WR_DATA = 8'h00;
  endtask

  // Leaves the bench sampling the cycle right after the k-th PERIOD_TICK.
  task automatic run_ticks(input int k, input int id);
    int guard;
    for (int n = 0; n < k; n++) begin
      guard = 0;
      while (PERIOD_TICK !== 1'b1 && guard < 400) begin
        cyc();
        guard++;
      end
      if (guard >= 400) begin
        total++;
        bad++;
        $display("FAIL tick_timeout[%0d] got=none exp=tick", id);
        return;
      end
      cyc();
    end
  endtask

  task automatic addw(input logic [1:0] a, input logic [7:0] d,
                      input logic [7:0] du, input logic b, input logic dn);
    vec_t v;
    v.wr = 1'b1; v.addr = a; v.data = d; v.ticks = 0; v.extra = 0;
    v.duty = du; v.busy = b; v.done = dn;
    vt.push_back(v);
  endtask

  task automatic addt(input int t, input int e, input logic [7:0] du, input logic b, input logic dn);
    vec_t v;
    v.wr = 1'b0; v.addr = 2'd0; v.data = 8'h00; v.ticks = t; v.extra = e;
    v.duty = du; v.busy = b; v.done = dn;
    vt.push_back(v);
  endtask

  task automatic apply(input int i);
    if (vt[i].wr) wr(vt[i].addr, vt[i].data);
    run_ticks(vt[i].ticks, i);
    repeat (vt[i].extra) cyc();
    chk("duty", i, 32'(DUTY), 32'(vt[i].duty));
    chk("busy", i, 32'(BUSY), 32'(vt[i].busy));
    chk("done", i, 32'(DONE), 32'(vt[i].done));
  endtask

  initial begin
    int split;
    int ticks_seen, first_tick, second_tick, duty_bad, busy_bad;

    // Up-ramp 0x00 -> 0x40 in steps of 0x10 every period.
    addw(ADDR_STEP, 8'h10, 8'h00, 0, 0);
    addw(ADDR_RATE, 8'h00, 8'h00, 0, 0);
    addw(ADDR_CTRL, 8'h01, 8'h00, 0, 0);
    addw(ADDR_TARGET, 8'h40, 8'h00, 1, 0);
    addt(1, 0, 8'h10, 1, 0);
    addt(1, 0, 8'h20, 1, 0);
    addt(1, 0, 8'h30, 1, 0);
    addt(1, 0, 8'h40, 1, 1);
    addt(0, 1, 8'h40, 0, 0);
    // Down-ramp with RATE=1 and a clamped final step.
    addw(ADDR_STEP, 8'h30, 8'h40, 0, 0);
    addw(ADDR_RATE, 8'h01, 8'h40, 0, 0);
    addw(ADDR_TARGET, 8'h05, 8'h40, 1, 0);
    addt(1, 0, 8'h40, 1, 0);
    addt(1, 0, 8'h10, 1, 0);
    addt(1, 0, 8'h10, 1, 0);
    addt(1, 0, 8'h05, 1, 1);
    addt(0, 1, 8'h05, 0, 0);
    // Large step toward zero must not underflow.
    addw(ADDR_STEP, 8'h50, 8'h05, 0, 0);
    addw(ADDR_RATE, 8'h00, 8'h05, 0, 0);
    addw(ADDR_TARGET, 8'h00, 8'h05, 1, 0);
    addt(1, 0, 8'h00, 1, 1);
    addt(0, 1, 8'h00, 0, 0);
    // Immediate jump.
    addw(ADDR_CTRL, 8'h03, 8'h00, 0, 0);
    addw(ADDR_TARGET, 8'hFF, 8'h00, 1, 0);
    addt(1, 0, 8'hFF, 1, 1);
    addt(0, 1, 8'hFF, 0, 0);
    // Pause and resume mid-ramp.
    addw(ADDR_CTRL, 8'h01, 8'hFF, 0, 0);
    addw(ADDR_STEP, 8'h10, 8'hFF, 0, 0);
    addw(ADDR_TARGET, 8'h80, 8'hFF, 1, 0);
    addt(1, 0, 8'hEF, 1, 0);
    addt(1, 0, 8'hDF, 1, 0);
    addw(ADDR_CTRL, 8'h00, 8'hDF, 0, 0);
    addt(2, 0, 8'hDF, 0, 0);
    addw(ADDR_CTRL, 8'h01, 8'hDF, 1, 0);
    addt(1, 0, 8'hCF, 1, 0);
    addw(ADDR_STEP, 8'hAF, 8'hCF, 1, 0);
    addw(ADDR_TARGET, 8'h20, 8'hCF, 1, 0);
    split = vt.size();
    // After the retarget on the step edge the ramp continues to 0x80.
    addt(1, 0, 8'h80, 1, 1);
    addt(0, 1, 8'h80, 0, 0);
    addw(ADDR_STEP, 8'h00, 8'h80, 0, 0);
    addw(ADDR_TARGET, 8'h82, 8'h80, 1, 0);
    addt(1, 0, 8'h81, 1, 0);
    addt(1, 0, 8'h82, 1, 1);
    addt(0, 1, 8'h82, 0, 0);
    addw(ADDR_TARGET, 8'h82, 8'h82, 0, 0);
    addt(1, 0, 8'h82, 0, 0);
    addw(ADDR_STEP, 8'h10, 8'h82, 0, 0);
    addw(ADDR_TARGET, 8'h00, 8'h82, 1, 0);
    addt(1, 0, 8'h72, 1, 0);
    foreach (vt[i]) if (vt[i].done) exp_done++;

    RST = 1'b1; WR_EN = 1'b0; WR_ADDR = 2'd0; WR_DATA = 8'h00;
    repeat (3) cyc();
    chk("rst_duty", 0, 32'(DUTY), 32'h00);
    chk("rst_busy", 0, 32'(BUSY), 32'h0);
    chk("rst_done", 0, 32'(DONE), 32'h0);
    chk("rst_tick", 0, 32'(PERIOD_TICK), 32'h0);

    // Idle for 600 cycles: ticks land at count 255 and every 256 after.
    RST = 1'b0;
    ticks_seen = 0; first_tick = -1; second_tick = -1; duty_bad = 0; busy_bad = 0;
    for (int i = 0; i < 600; i++) begin
      if (PERIOD_TICK === 1'b1) begin
        if (ticks_seen == 0) first_tick = i;
        if (ticks_seen == 1) second_tick = i;
        ticks_seen++;
      end
      if (DUTY !== 8'h00) duty_bad++;
      if (BUSY !== 1'b0) busy_bad++;
      cyc();
    end
    chk("idle_first_tick", 0, 32'(first_tick), 32'd255);
    chk("idle_second_tick", 0, 32'(second_tick), 32'd511);
    chk("idle_tick_count", 0, 32'(ticks_seen), 32'd2);
    chk("idle_duty", 0, 32'(duty_bad), 32'd0);
    chk("idle_busy", 0, 32'(busy_bad), 32'd0);
    chk("idle_done", 0, 32'(done_seen), 32'd0);

    for (int i = 0; i < split; i++) apply(i);

    // Retarget 0x20 -> 0x80 on the very edge that brings DUTY to 0x20.
    run_ticks(0, 100);
    begin
      int guard;
      guard = 0;
      while (PERIOD_TICK !== 1'b1 && guard < 400) begin
        cyc();
        guard++;
      end
      chk("retarget_tick_found", 100, 32'(PERIOD_TICK), 32'h1);
    end
    wr(ADDR_TARGET, 8'h80);
    chk("retarget_duty", 100, 32'(DUTY), 32'h20);
    chk("retarget_done", 100, 32'(DONE), 32'h0);
    chk("retarget_busy", 100, 32'(BUSY), 32'h1);

    for (int i = split; i < vt.size(); i++) apply(i);

    // Reset mid-ramp (ramp from 0x72 toward 0x00 in progress).
    RST = 1'b1;
    cyc();
    chk("midrst_duty", 200, 32'(DUTY), 32'h00);
    chk("midrst_busy", 200, 32'(BUSY), 32'h0);
    chk("midrst_done", 200, 32'(DONE), 32'h0);
    chk("midrst_tick", 200, 32'(PERIOD_TICK), 32'h0);
    RST = 1'b0;
    wr(ADDR_TARGET, 8'h10);
    chk("postrst_busy", 201, 32'(BUSY), 32'h0);
    run_ticks(1, 201);
    chk("postrst_duty", 201, 32'(DUTY), 32'h00);
    chk("postrst_busy2", 201, 32'(BUSY), 32'h0);

    chk("done_pulses", 300, 32'(done_seen), 32'(exp_done));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
